dcache_wb_param: RTL and testbench

//  Parametrised direct-mapped, write-back, write-allocate data cache between the control unit/ALU and data_mem.

---
 rtl/dcache_wb_param.sv | 147 ++++++++++++++
 tb/tb_dcache_wb_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_param.sv
// rtl/dcache_wb_param.sv - direct-mapped write-back write-allocate data cache with hit/miss counters
module dcache_wb_param #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LINES  = 8,
    parameter int WORDS  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              read,
    input  logic                              write,
    input  logic [ADDR_W-1:0]                 address,
    input  logic [DATA_W-1:0]                 writedata,
    output logic [DATA_W-1:0]                 readdata,
    output logic                              busywait,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic [ADDR_W-$clog2(WORDS)-1:0]   mem_address,
    output logic [DATA_W*WORDS-1:0]           mem_writedata,
    input  logic [DATA_W*WORDS-1:0]           mem_readdata,
    input  logic                              mem_busywait,
    output logic [CNT_W-1:0]                  hit_count,
    output logic [CNT_W-1:0]                  miss_count
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {IDLE, WBACK, ALLOC, FILL} state_t;
    state_t state;

    logic [DATA_W-1:0]        data_arr [LINES][WORDS];
    logic [TAG_W-1:0]         tag_arr  [LINES];
    logic [LINES-1:0]         valid;
    logic [LINES-1:0]         dirty;
    logic                     retry;
    logic                     armed;

    logic [TAG_W-1:0]         tag;
    logic [IDX_W-1:0]         idx;
    logic [OFF_W-1:0]         off;
    logic                     access;
    logic                     hit;
    logic [DATA_W*WORDS-1:0]  line_cur;

    assign tag    = address[ADDR_W-1:OFF_W+IDX_W];
    assign idx    = address[OFF_W +: IDX_W];
    assign off    = address[OFF_W-1:0];
    assign access = read ^ write;
    assign hit    = valid[idx] && (tag_arr[idx] == tag);

    assign readdata = (read && hit && state == IDLE) ? data_arr[idx][off] : '0;
    // Gated by rst so a stalled CPU is released the instant reset asserts.
    assign busywait = rst && access && !(hit && state == IDLE);

    always_comb begin
        line_cur = '0;
        for (int w = 0; w < WORDS; w++) begin
            line_cur[w*DATA_W +: DATA_W] = data_arr[idx][w];
        end
    end

    // armed: the request has been up for at least one full cycle, so a
    // low mem_busywait now really means the transfer finished.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            valid         <= '0;
            dirty         <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            retry         <= 1'b0;
            armed         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    retry <= 1'b0;
                    armed <= 1'b0;
                    if (access) begin
                        if (hit) begin
                            if (!retry && hit_count != '1) hit_count <= hit_count + 1'b1;
                            if (write) dirty[idx] <= 1'b1;
                        end else begin
                            if (miss_count != '1) miss_count <= miss_count + 1'b1;
                            if (dirty[idx]) begin
                                state         <= WBACK;
                                mem_write     <= 1'b1;
                                mem_address   <= {tag_arr[idx], idx};
                                mem_writedata <= line_cur;
                            end else begin
                                state       <= ALLOC;
                                mem_read    <= 1'b1;
                                mem_address <= {tag, idx};
                            end
                        end
                    end
                end
                WBACK: begin
                    if (armed && !mem_busywait) begin
                        mem_write <= 1'b0;
                        armed     <= 1'b0;
                        state     <= ALLOC;
                    end else begin
                        armed <= 1'b1;
                    end
                end
                ALLOC: begin
                    if (!mem_read) begin
                        mem_read    <= 1'b1;
                        mem_address <= {tag, idx};
                    end else if (armed && !mem_busywait) begin
                        mem_read <= 1'b0;
                        armed    <= 1'b0;
                        state    <= FILL;
                    end else begin
                        armed <= 1'b1;
                    end
                end
                FILL: begin
                    valid[idx] <= 1'b1;
                    dirty[idx] <= 1'b0;
                    retry      <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tag storage is deliberately not reset; valid bits gate it.
    always_ff @(posedge clk) begin
        if (state == IDLE && write && !read && hit) begin
            data_arr[idx][off] <= writedata;
        end
        if (state == FILL) begin
            tag_arr[idx] <= tag;
            for (int w = 0; w < WORDS; w++) begin
                data_arr[idx][w] <= mem_readdata[w*DATA_W +: DATA_W];
            end
        end
    end
endmodule

// File: tb/tb_dcache_wb_param.sv
// tb/tb_dcache_wb_param.sv - directed and randomized checks of dcache_wb_param against a reference model
module tb_dcache_wb_param;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        read, write;
    logic [7:0]  address, writedata, readdata;
    logic        busywait, mem_read, mem_write, mem_busywait;
    logic [6:0]  mem_address;
    logic [15:0] mem_writedata, mem_readdata;
    logic [3:0]  hit_count, miss_count;

    logic [15:0] mem [128];
    int          mem_cnt = 0;
    int          req_cycles = 0;
    logic [6:0]  wb_addr = '0, rd_addr = '0;
    logic [15:0] wb_data = '0;
    int          n_cmp = 0, n_bad = 0;

    dcache_wb_param #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(readdata), .busywait(busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_busywait(mem_busywait), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    assign mem_readdata = mem[mem_address];
    assign mem_busywait = (mem_read || mem_write) && mem_cnt >= 1 && mem_cnt < LAT;

    always @(posedge clk) begin
        if (mem_read || mem_write) begin
            if (mem_cnt >= LAT && mem_write) mem[mem_address] <= mem_writedata;
            mem_cnt    <= mem_cnt + 1;
            req_cycles <= req_cycles + 1;
        end else begin
            mem_cnt <= 0;
        end
        if (mem_write) begin
            wb_addr <= mem_address;
            wb_data <= mem_writedata;
        end
        if (mem_read) rd_addr <= mem_address;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a posedge; returns one cycle after the access completes.
    task automatic do_access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                             output logic [7:0] rdata, output logic bw0);
        read = rd; write = wr; address = a; writedata = wd;
        @(negedge clk);
        bw0 = busywait;
        for (int n = 0; n < 100 && busywait; n++) @(negedge clk);
        if (busywait) check("timeout", 32'(busywait), 32'd0);
        rdata = readdata;
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    logic [7:0] ref_byte [256];
    logic [3:0] m_tag [8];
    logic [7:0] m_valid;
    int         m_hits, m_miss;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rdv;
        logic       bw;
        int         req_before;

        for (int b = 0; b < 128; b++) mem[b] = {8'(b*2+1), 8'(b*2)};
        rst = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busywait", 32'(busywait), 0);
        check("rst_mem_read", 32'(mem_read), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_mem_addr", 32'(mem_address), 0);
        check("rst_hits", 32'(hit_count), 0);
        check("rst_miss", 32'(miss_count), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        do_access(1, 0, 8'h19, 8'h00, rdv, bw);
        check("t1_bw", 32'(bw), 1);
        check("t1_rd_addr", 32'(rd_addr), 32'h0C);
        check("t1_data", 32'(rdv), 32'h19);
        check("t1_miss", 32'(miss_count), 1);
        check("t1_hits", 32'(hit_count), 0);

        do_access(0, 1, 8'h19, 8'h2D, rdv, bw);
        check("t2_wr_bw", 32'(bw), 0);
        check("t2_hits1", 32'(hit_count), 1);
        do_access(1, 0, 8'h19, 8'h00, rdv, bw);
        check("t2_rd19", 32'(rdv), 32'h2D);
        do_access(1, 0, 8'h18, 8'h00, rdv, bw);
        check("t2_rd18", 32'(rdv), 32'h18);
        check("t2_hits3", 32'(hit_count), 3);

        do_access(1, 0, 8'h39, 8'h00, rdv, bw);
        check("t3_bw", 32'(bw), 1);
        check("t3_wb_addr", 32'(wb_addr), 32'h0C);
        check("t3_wb_data", 32'(wb_data), 32'h2D18);
        check("t3_rd_addr", 32'(rd_addr), 32'h1C);
        check("t3_data", 32'(rdv), 32'h39);
        check("t3_miss", 32'(miss_count), 2);
        check("t3_mem", 32'(mem[12]), 32'h2D18);

        read = 1'b1; address = 8'h19;
        for (int n = 0; n < 50 && !mem_read; n++) @(negedge clk);
        check("t4_req_seen", 32'(mem_read), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t4_mem_read", 32'(mem_read), 0);
        check("t4_busywait", 32'(busywait), 0);
        @(posedge clk); #1;
        read = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        do_access(1, 0, 8'h19, 8'h00, rdv, bw);
        check("t4_bw", 32'(bw), 1);
        check("t4_data", 32'(rdv), 32'h2D);
        check("t4_miss", 32'(miss_count), 1);
        check("t4_hits", 32'(hit_count), 0);

        req_before = req_cycles;
        do_access(1, 1, 8'h19, 8'hAA, rdv, bw);
        check("t5_bw", 32'(bw), 0);
        check("t5_no_req", 32'(req_cycles - req_before), 0);
        check("t5_hits", 32'(hit_count), 0);
        check("t5_miss", 32'(miss_count), 1);
        do_access(1, 0, 8'h19, 8'h00, rdv, bw);
        check("t5_data_kept", 32'(rdv), 32'h2D);

        for (int i = 0; i < 20; i++) do_access(1, 0, 8'h19, 8'h00, rdv, bw);
        check("t6_hits_sat", 32'(hit_count), 15);
        check("t6_miss", 32'(miss_count), 1);

        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int a = 0; a < 256; a++) ref_byte[a] = a[0] ? mem[a >> 1][15:8] : mem[a >> 1][7:0];
        m_valid = '0; m_hits = 0; m_miss = 0;
        for (int l = 0; l < 8; l++) m_tag[l] = '0;
        @(posedge clk); #1;

        for (int i = 0; i < 200; i++) begin
            int         kind;
            logic [7:0] a, wd;
            logic [2:0] ix;
            logic       mh;
            kind = $urandom_range(0, 19);
            a    = 8'($urandom_range(0, 63));
            wd   = 8'($urandom);
            ix   = a[3:1];
            mh   = m_valid[ix] && m_tag[ix] == a[7:4];
            if (kind >= 19) begin
                do_access(1, 1, a, wd, rdv, bw);
                check("rand_both_bw", 32'(bw), 0);
            end else begin
                do_access(kind < 11, kind >= 11, a, wd, rdv, bw);
                check("rand_bw", 32'(bw), 32'(!mh));
                if (mh) m_hits++;
                else begin
                    m_miss++;
                    m_valid[ix] = 1'b1;
                    m_tag[ix]   = a[7:4];
                end
                if (kind >= 11) ref_byte[a] = wd;
                else check("rand_data", 32'(rdv), 32'(ref_byte[a]));
            end
            check("rand_hits", 32'(hit_count), (m_hits > 15) ? 15 : m_hits);
            check("rand_miss", 32'(miss_count), (m_miss > 15) ? 15 : m_miss);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
